rx_frame_sched: RTL and testbench

Output scheduler for the multi-receiver front end. It collects one decimated I/Q sample from each enabled `receiver` instance, which strobes independently after the `firX2R2` output stage. It then emits them as a single ordered frame over a valid/ready stream towards the host packetizer. It buffers one sample per receiver, reports per-receiver overruns, and keeps frame membership stable while a frame is in flight.

---
 rtl/rx_pkg.sv | 44 ++++
 rtl/rx_frame_sched_if.sv | 34 +++
 rtl/rx_slot_buf.sv | 61 ++++++
 rtl/rx_frame_sched.sv | 120 ++++++++++++
 tb/tb_rx_frame_sched.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rx_pkg.sv
// Shared definitions for the receiver output scheduler: sizes, FSM state type
// and the bit-scan helpers used to walk a frame's membership mask.
package rx_pkg;

   localparam int DEF_DW = 24;
   localparam int MAX_RX = 8;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } sched_state_t;

   typedef logic [MAX_RX-1:0] rx_mask_t;
   typedef logic [2:0]        rx_idx_t;

   // Lowest set bit strictly above 'from'; returns 'from' when none exists.
   function automatic rx_idx_t next_set_bit(input rx_mask_t mask, input rx_idx_t from);
      rx_idx_t r;
      r = from;
      for (int i = MAX_RX - 1; i >= 0; i--) begin
         if (mask[i] && (i > int'(from))) r = rx_idx_t'(i);
      end
      return r;
   endfunction

   function automatic rx_idx_t lowest_set(input rx_mask_t mask);
      rx_idx_t r;
      r = '0;
      for (int i = MAX_RX - 1; i >= 0; i--) begin
         if (mask[i]) r = rx_idx_t'(i);
      end
      return r;
   endfunction

   function automatic rx_idx_t highest_set(input rx_mask_t mask);
      rx_idx_t r;
      r = '0;
      for (int i = 0; i < MAX_RX; i++) begin
         if (mask[i]) r = rx_idx_t'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/rx_frame_sched_if.sv
// Output word stream from the scheduler to the host packetizer.
// A word transfers on a clock edge where out_valid && out_ready; while out_valid
// is high and out_ready low every field is held and out_valid stays high.
interface rx_frame_sched_if #(
   parameter int DW = 24
);
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_I;
   logic [DW-1:0] out_Q;
   logic [2:0]    out_rx;
   logic          out_first;
   logic          out_last;

   modport master (
      output out_valid,
      input  out_ready,
      output out_I,
      output out_Q,
      output out_rx,
      output out_first,
      output out_last
   );

   modport slave (
      input  out_valid,
      output out_ready,
      input  out_I,
      input  out_Q,
      input  out_rx,
      input  out_first,
      input  out_last
   );
endinterface

// File: rtl/rx_slot_buf.sv
// One-sample holding register for a single receiver slot, with its full flag
// and sticky overrun flag.
module rx_slot_buf
   import rx_pkg::*;
#(
   parameter int DW = DEF_DW
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          enable,
   input  logic          member,
   input  logic          strobe,
   input  logic [DW-1:0] data_I,
   input  logic [DW-1:0] data_Q,
   input  logic          accept,
   input  logic          clear_overrun,
   output logic [DW-1:0] hold_I,
   output logic [DW-1:0] hold_Q,
   output logic          full,
   output logic          overrun
);

   logic capture;
   logic drop;

   assign capture = strobe && enable;
   // A sample arriving while the slot is still occupied and not being drained is lost.
   assign drop    = capture && full && !accept;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hold_I <= '0;
         hold_Q <= '0;
         full   <= 1'b0;
      end else if (accept) begin
         full <= capture;
         if (capture) begin
            hold_I <= data_I;
            hold_Q <= data_Q;
         end
      end else if (!enable && !member) begin
         full <= 1'b0;
      end else if (capture && !full) begin
         hold_I <= data_I;
         hold_Q <= data_Q;
         full   <= 1'b1;
      end
   end

   // A new drop wins over a simultaneous clear.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (clear_overrun) begin
         overrun <= 1'b0;
      end
   end

endmodule

// File: rtl/rx_frame_sched.sv
// Collects one sample per enabled receiver slot and emits them as one ordered
// frame (ascending slot index) on a valid/ready stream.
module rx_frame_sched
   import rx_pkg::*;
#(
   parameter int NUM_RX = 4,
   parameter int DW     = DEF_DW
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_RX-1:0]    enable,
   input  logic [NUM_RX-1:0]    in_strobe,
   input  logic [NUM_RX*DW-1:0] in_I,
   input  logic [NUM_RX*DW-1:0] in_Q,
   rx_frame_sched_if.master     bus,
   output logic [NUM_RX-1:0]    overrun,
   input  logic                 clear_overrun,
   output sched_state_t         state
);

   rx_mask_t      en_w;
   rx_mask_t      en_frame;
   rx_mask_t      full;
   logic [DW-1:0] hold_I [MAX_RX];
   logic [DW-1:0] hold_Q [MAX_RX];
   logic          in_send;
   logic          fire;
   logic          frame_ready;
   rx_idx_t       start_idx;
   rx_idx_t       start_last;
   rx_idx_t       nxt_idx;
   rx_idx_t       frame_last;

   assign en_w    = rx_mask_t'(enable);
   assign in_send = (state == SEND);
   assign fire    = bus.out_valid && bus.out_ready;

   for (genvar k = 0; k < MAX_RX; k++) begin : g_slot
      if (k < NUM_RX) begin : g_used
         rx_slot_buf #(
            .DW(DW)
         ) u_buf (
            .clock         (clock),
            .reset         (reset),
            .enable        (enable[k]),
            .member        (in_send && en_frame[k]),
            .strobe        (in_strobe[k]),
            .data_I        (in_I[k*DW +: DW]),
            .data_Q        (in_Q[k*DW +: DW]),
            .accept        (fire && (bus.out_rx == rx_idx_t'(k))),
            .clear_overrun (clear_overrun),
            .hold_I        (hold_I[k]),
            .hold_Q        (hold_Q[k]),
            .full          (full[k]),
            .overrun       (overrun[k])
         );
      end else begin : g_unused
         assign hold_I[k] = '0;
         assign hold_Q[k] = '0;
         assign full[k]   = 1'b0;
      end
   end

   // A frame may start only when every currently enabled slot holds a sample.
   assign frame_ready = (en_w != '0) && ((full & en_w) == en_w);
   assign start_idx   = lowest_set(en_w);
   assign start_last  = highest_set(en_w);
   assign nxt_idx     = next_set_bit(en_frame, bus.out_rx);
   assign frame_last  = highest_set(en_frame);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         en_frame      <= '0;
         bus.out_valid <= 1'b0;
         bus.out_I     <= '0;
         bus.out_Q     <= '0;
         bus.out_rx    <= '0;
         bus.out_first <= 1'b0;
         bus.out_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               en_frame <= en_w;
               if (frame_ready) begin
                  state         <= SEND;
                  bus.out_valid <= 1'b1;
                  bus.out_rx    <= start_idx;
                  bus.out_I     <= hold_I[start_idx];
                  bus.out_Q     <= hold_Q[start_idx];
                  bus.out_first <= 1'b1;
                  bus.out_last  <= (start_idx == start_last);
               end
            end
            SEND: begin
               // en_frame is frozen here, so mid-frame enable changes wait for the next frame.
               if (fire) begin
                  if (bus.out_last) begin
                     state         <= IDLE;
                     bus.out_valid <= 1'b0;
                     bus.out_first <= 1'b0;
                     bus.out_last  <= 1'b0;
                  end else begin
                     bus.out_rx    <= nxt_idx;
                     bus.out_I     <= hold_I[nxt_idx];
                     bus.out_Q     <= hold_Q[nxt_idx];
                     bus.out_first <= 1'b0;
                     bus.out_last  <= (nxt_idx == frame_last);
                  end
               end
            end
            default: begin
               state         <= IDLE;
               bus.out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_frame_sched.sv
// Bench for rx_frame_sched: directed scenarios plus random traffic, all checked
// against a cycle-level model built from per-slot buffers and a frame word queue.
module tb_rx_frame_sched;
  import rx_pkg::*;

  localparam int N = 4;
  localparam int W = 24;

  // clock / reset
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [N-1:0]   enable;
  logic [N-1:0]   in_strobe;
  logic [N*W-1:0] in_I;
  logic [N*W-1:0] in_Q;
  logic [N-1:0]   overrun;
  logic           clear_overrun;
  logic           ready;
  sched_state_t   state;

  rx_frame_sched_if #(.DW(W)) bus ();
  assign bus.out_ready = ready;

  rx_frame_sched #(
    .NUM_RX(N),
    .DW    (W)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .in_strobe     (in_strobe),
    .in_I          (in_I),
    .in_Q          (in_Q),
    .bus           (bus.master),
    .overrun       (overrun),
    .clear_overrun (clear_overrun),
    .state         (state)
  );

  // reference model: slot buffers plus the queue of slots still to be sent in the frame
  logic [N-1:0] m_full;
  logic [N-1:0] m_ovr;
  logic [N-1:0] m_frame;
  logic [W-1:0] m_I [N];
  logic [W-1:0] m_Q [N];
  logic [2:0]   exp_q[$];
  int           m_sent;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_full  = '0;
    m_ovr   = '0;
    m_frame = '0;
    m_sent  = 0;
    exp_q.delete();
    for (int k = 0; k < N; k++) begin
      m_I[k] = '0;
      m_Q[k] = '0;
    end
  endtask

  // One clock edge of the model, using the inputs held across that edge.
  task automatic model_step();
    bit busy, acc, start, cap, took, keep;
    int front;
    busy  = exp_q.size() > 0;
    front = busy ? int'(exp_q[0]) : -1;
    acc   = busy && ready;
    start = !busy && (enable != '0) && ((enable & m_full) == enable);
    for (int k = 0; k < N; k++) begin
      cap  = in_strobe[k] && enable[k];
      took = acc && (front == k);
      keep = busy && m_frame[k];
      if (cap && m_full[k] && !took) m_ovr[k] = 1'b1;
      else if (clear_overrun)        m_ovr[k] = 1'b0;
      if (cap && (took || !m_full[k])) begin
        m_I[k] = in_I[k*W +: W];
        m_Q[k] = in_Q[k*W +: W];
      end
      if (took)                      m_full[k] = cap;
      else if (!enable[k] && !keep)  m_full[k] = 1'b0;
      else if (cap)                  m_full[k] = 1'b1;
    end
    if (acc) begin
      void'(exp_q.pop_front());
      m_sent++;
    end
    if (start) begin
      m_frame = enable;
      m_sent  = 0;
      for (int k = 0; k < N; k++) if (enable[k]) exp_q.push_back(3'(k));
    end
  endtask

  task automatic compare();
    bit busy;
    int k;
    busy = exp_q.size() > 0;
    check("out_valid", bus.out_valid, busy);
    check("state", state == SEND, busy);
    if (busy) begin
      k = int'(exp_q[0]);
      check("out_rx", bus.out_rx, exp_q[0]);
      check("out_I", bus.out_I, m_I[k]);
      check("out_Q", bus.out_Q, m_Q[k]);
      check("out_first", bus.out_first, m_sent == 0);
      check("out_last", bus.out_last, exp_q.size() == 1);
    end
    check("overrun", overrun, m_ovr);
  endtask

  // driver tasks: inputs change at negedge, outputs are compared at the next negedge
  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare();
    in_strobe     = '0;
    clear_overrun = 1'b0;
  endtask

  task automatic strobe_slot(input int k, input logic [W-1:0] i_val, input logic [W-1:0] q_val);
    in_strobe          = '0;
    in_strobe[k]       = 1'b1;
    in_I[k*W +: W]     = i_val;
    in_Q[k*W +: W]     = q_val;
    cycle();
  endtask

  task automatic strobe_basic();
    strobe_slot(0, W'(0),  W'(0));
    strobe_slot(1, W'(16), W'(-1));
    strobe_slot(3, W'(48), W'(-3));
  endtask

  initial begin
    reset         = 1'b1;
    enable        = '0;
    in_strobe     = '0;
    in_I          = '0;
    in_Q          = '0;
    clear_overrun = 1'b0;
    ready         = 1'b1;
    model_clear();
    repeat (2) @(negedge clock);
    check("rst_valid", bus.out_valid, 0);
    check("rst_I", bus.out_I, 0);
    check("rst_Q", bus.out_Q, 0);
    check("rst_rx", bus.out_rx, 0);
    check("rst_first", bus.out_first, 0);
    check("rst_last", bus.out_last, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", state, IDLE);
    reset = 1'b0;
    cycle();

    // basic frame: slots 0,1,3
    enable = 4'b1011;
    strobe_basic();
    check("lat_idle", bus.out_valid, 0);
    cycle();
    check("basic_w0_rx", bus.out_rx, 0);
    check("basic_w0_first", bus.out_first, 1);
    cycle();
    check("basic_w1_rx", bus.out_rx, 1);
    check("basic_w1_I", bus.out_I, 16);
    cycle();
    check("basic_w2_rx", bus.out_rx, 3);
    check("basic_w2_last", bus.out_last, 1);
    check("basic_w2_Q", bus.out_Q, 24'hfffffd);
    cycle();
    check("basic_done", bus.out_valid, 0);
    check("basic_ovr", overrun, 0);

    // backpressure on the second word
    strobe_basic();
    cycle();
    cycle();
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_hold_rx", bus.out_rx, 1);
      check("bp_hold_valid", bus.out_valid, 1);
    end
    ready = 1'b1;
    cycle();
    check("bp_w2_rx", bus.out_rx, 3);
    cycle();
    check("bp_done", bus.out_valid, 0);

    // overrun on slot 2, then clears, then clear coinciding with a new drop
    enable = 4'b0101;
    strobe_slot(2, 24'ha5a5a5, 24'h010101);
    strobe_slot(2, 24'h5a5a5a, 24'h020202);
    check("ovr_set", overrun, 4'b0100);
    strobe_slot(0, 24'h000abc, 24'h000def);
    cycle();
    cycle();
    check("ovr_first_kept", bus.out_I, 24'ha5a5a5);
    cycle();
    check("ovr_sticky", overrun, 4'b0100);
    clear_overrun = 1'b1;
    cycle();
    check("ovr_cleared", overrun, 0);
    strobe_slot(2, 24'h123456, 24'h654321);
    clear_overrun = 1'b1;
    strobe_slot(2, 24'h777777, 24'h888888);
    check("ovr_set_wins", overrun, 4'b0100);
    clear_overrun = 1'b1;
    cycle();
    strobe_slot(0, 24'h000001, 24'h000002);
    repeat (3) cycle();

    // enable change mid-frame
    enable = 4'b0011;
    ready  = 1'b0;
    strobe_slot(0, 24'h100000, 24'h100001);
    strobe_slot(1, 24'h110000, 24'h110001);
    cycle();
    enable = 4'b0111;
    strobe_slot(2, 24'h120000, 24'h120001);
    ready = 1'b1;
    cycle();
    check("enchg_last_rx", bus.out_rx, 1);
    check("enchg_last", bus.out_last, 1);
    cycle();
    check("enchg_end", bus.out_valid, 0);
    strobe_slot(0, 24'h200000, 24'h200001);
    strobe_slot(1, 24'h210000, 24'h210001);
    cycle();
    cycle();
    cycle();
    check("enchg_join_rx", bus.out_rx, 2);
    check("enchg_join_I", bus.out_I, 24'h120000);
    cycle();

    // accept and strobe of slot 0 on the same edge
    enable = 4'b0011;
    strobe_slot(0, 24'h000111, 24'h000011);
    strobe_slot(1, 24'h000333, 24'h000033);
    cycle();
    strobe_slot(0, 24'h000222, 24'h000022);
    check("coll_no_ovr", overrun, 0);
    cycle();
    strobe_slot(1, 24'h000444, 24'h000044);
    cycle();
    check("coll_kept_I", bus.out_I, 24'h000222);
    cycle();
    cycle();

    // reset in the middle of a frame
    enable = 4'b1011;
    strobe_basic();
    cycle();
    cycle();
    reset = 1'b1;
    #1;
    check("rstmid_valid", bus.out_valid, 0);
    check("rstmid_state", state, IDLE);
    model_clear();
    @(negedge clock);
    reset = 1'b0;
    strobe_slot(0, 24'h0000aa, 24'h0000bb);
    strobe_slot(1, 24'h0000cc, 24'h0000dd);
    repeat (3) cycle();
    check("rstmid_no_out", bus.out_valid, 0);
    strobe_slot(3, 24'h0000ee, 24'h0000ff);
    cycle();
    check("rstmid_new_rx", bus.out_rx, 0);
    check("rstmid_new_I", bus.out_I, 24'h0000aa);
    repeat (3) cycle();

    // random traffic
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 19) == 0) enable = 4'($urandom_range(1, 15));
      for (int k = 0; k < N; k++) begin
        in_strobe[k]   = ($urandom_range(0, 2) == 0);
        in_I[k*W +: W] = W'($urandom);
        in_Q[k*W +: W] = W'($urandom);
      end
      ready         = ($urandom_range(0, 3) != 0);
      clear_overrun = ($urandom_range(0, 29) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
